// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
package sipo_pkg;

  typedef enum logic {
    HUNT,
    RECV
  } state_t;

  // Bit counter spans 0..n-1, so at least one bit is always needed.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// Output word holding register with valid/ready handoff and sticky overrun.
module sipo_out_buf #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         word_done,
  input  logic [N-1:0] word,
  input  logic         ready,
  input  logic         clr_ovr,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         overrun
);

  logic xfer;
  logic load;
  logic drop;

  assign xfer = valid && ready;
  assign load = word_done && (!valid || ready);
  assign drop = word_done && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= word;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with sync-based word alignment.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_serial_in,
  input  logic         i_serial_valid,
  input  logic         i_sync,
  output logic [N-1:0] o_parallel_out,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_overrun,
  input  logic         i_clr_ovr,
  output logic         o_frame_err
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [CW-1:0]  count;
  logic [N-1:0]   shreg;
  logic           frame_err;
  logic [N-1:0]   word;
  logic           done;

  assign word = {shreg[N-2:0], i_serial_in};

  assign done = i_serial_valid && (state == RECV)
             && !i_sync && (count == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= HUNT;
      count     <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (i_serial_valid) begin
        unique case (state)
          HUNT: begin
            if (i_sync) begin
              shreg <= {{(N-1){1'b0}}, i_serial_in};
              count <= CW'(1);
              state <= RECV;
            end
          end
          RECV: begin
            if (i_sync) begin
              // Resync: drop any partial word, restart at this bit.
              frame_err <= (count != '0);
              shreg     <= {{(N-1){1'b0}}, i_serial_in};
              count     <= CW'(1);
            end else begin
              shreg <= word;
              count <= (count == LAST) ? '0 : count + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign o_frame_err = frame_err;

  sipo_out_buf #(
    .N(N)
  ) u_out_buf (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .word_done(done),
    .word     (word),
    .ready    (i_ready),
    .clr_ovr  (i_clr_ovr),
    .data     (o_parallel_out),
    .valid    (o_valid),
    .overrun  (o_overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser with N=4.
module tb_sipo_deser;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sval;
  logic       sync;
  logic [3:0] pout;
  logic       valid;
  logic       ready;
  logic       ovr;
  logic       clr;
  logic       ferr;

  int total;
  int fails;

  sipo_deser #(
    .N(4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_serial_in   (sin),
    .i_serial_valid(sval),
    .i_sync        (sync),
    .o_parallel_out(pout),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_overrun     (ovr),
    .i_clr_ovr     (clr),
    .o_frame_err   (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic s);
    @(negedge clk);
    sval = 1'b1;
    sin  = b;
    sync = s;
  endtask

  task automatic idle();
    @(negedge clk);
    sval = 1'b0;
    sin  = 1'b0;
    sync = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst_n = 1'b0;
    sin   = 1'b0;
    sval  = 1'b0;
    sync  = 1'b0;
    ready = 1'b1;
    clr   = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(pout), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic word 1011
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    after_edge();
    chk("w1_valid", 32'(valid), 32'd1);
    chk("w1_data", 32'(pout), 32'hB);
    chk("w1_ferr", 32'(ferr), 32'd0);
    idle();
    after_edge();
    chk("w1_drain", 32'(valid), 32'd0);
    chk("w1_hold", 32'(pout), 32'hB);

    // overrun: ready low, 1011 then 0110
    ready = 1'b0;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    after_edge();
    chk("ov_w1_valid", 32'(valid), 32'd1);
    chk("ov_w1_ovr", 32'(ovr), 32'd0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    after_edge();
    chk("ov_data", 32'(pout), 32'hB);
    chk("ov_valid", 32'(valid), 32'd1);
    chk("ov_flag", 32'(ovr), 32'd1);
    idle();
    @(negedge clk);
    clr = 1'b1;
    after_edge();
    chk("ov_clr", 32'(ovr), 32'd0);
    @(negedge clk);
    clr   = 1'b0;
    ready = 1'b1;
    after_edge();
    chk("ov_drain", 32'(valid), 32'd0);

    // gaps between bits
    send(1'b1, 1'b1);
    idle();
    send(1'b0, 1'b0);
    idle();
    idle();
    send(1'b1, 1'b0);
    idle();
    after_edge();
    chk("gap_nocomp", 32'(valid), 32'd0);
    send(1'b1, 1'b0);
    after_edge();
    chk("gap_valid", 32'(valid), 32'd1);
    chk("gap_data", 32'(pout), 32'hB);
    idle();
    after_edge();
    chk("gap_drain", 32'(valid), 32'd0);

    // resync mid-word, then 1010
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    after_edge();
    chk("fe_pulse", 32'(ferr), 32'd1);
    send(1'b0, 1'b0);
    after_edge();
    chk("fe_clear", 32'(ferr), 32'd0);
    chk("fe_nocomp", 32'(valid), 32'd0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    after_edge();
    chk("fe_valid", 32'(valid), 32'd1);
    chk("fe_data", 32'(pout), 32'hA);
    idle();
    after_edge();
    chk("fe_drain", 32'(valid), 32'd0);

    // reset mid-word, unsynced bits ignored
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    @(negedge clk);
    sval  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_data", 32'(pout), 32'h0);
    chk("mr_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    after_edge();
    chk("mr_hunt", 32'(valid), 32'd0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    after_edge();
    chk("mr_nocomp", 32'(valid), 32'd0);
    send(1'b0, 1'b0);
    after_edge();
    chk("mr_valid2", 32'(valid), 32'd1);
    chk("mr_data2", 32'(pout), 32'h6);
    idle();
    after_edge();
    chk("mr_drain", 32'(valid), 32'd0);

    // back-to-back words 1100, 0011
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    after_edge();
    chk("bb_w1_valid", 32'(valid), 32'd1);
    chk("bb_w1_data", 32'(pout), 32'hC);
    send(1'b0, 1'b1);
    after_edge();
    chk("bb_xfer1", 32'(valid), 32'd0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    after_edge();
    chk("bb_w2_valid", 32'(valid), 32'd1);
    chk("bb_w2_data", 32'(pout), 32'h3);
    chk("bb_ovr", 32'(ovr), 32'd0);
    idle();
    after_edge();
    chk("bb_drain", 32'(valid), 32'd0);

    // completion coincident with transfer: 1001 held, 0110 replaces it
    ready = 1'b0;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    after_edge();
    chk("sx_hold", 32'(pout), 32'h9);
    send(1'b0, 1'b0);
    ready = 1'b1;
    after_edge();
    chk("sx_valid", 32'(valid), 32'd1);
    chk("sx_data", 32'(pout), 32'h6);
    chk("sx_ovr", 32'(ovr), 32'd0);
    idle();
    after_edge();
    chk("sx_drain", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
